// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: default 640x480@60 timing constants and polarity defaults
// shared by the horizontal counter, sync generator and text/font stages.
package vga_sync_gen_pkg;
   localparam int H_VISIBLE_D = 640;
   localparam int H_FP_D      = 16;
   localparam int H_SYNC_D    = 96;
   localparam int H_BP_D      = 48;
   localparam int V_VISIBLE_D = 480;
   localparam int V_FP_D      = 10;
   localparam int V_SYNC_D    = 2;
   localparam int V_BP_D      = 33;
   localparam int HSYNC_POL_D = 0;
   localparam int VSYNC_POL_D = 0;
   localparam int CHAR_W_D    = 8;
   localparam int CHAR_H_D    = 16;
   typedef logic [9:0] coord_t;
   function automatic int total(int vis, int fp, int sync, int bp);
      return vis + fp + sync + bp;
   endfunction
   localparam int H_TOTAL_D = total(H_VISIBLE_D, H_FP_D, H_SYNC_D, H_BP_D);
   localparam int V_TOTAL_D = total(V_VISIBLE_D, V_FP_D, V_SYNC_D, V_BP_D);
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: horizontal address/line-advance in, sync/enable/coordinates out.
interface vga_sync_gen_if;
   import vga_sync_gen_pkg::*;
   coord_t     HADDR;
   logic       HTC;
   coord_t     VADDR;
   logic       HSYNC;
   logic       VSYNC;
   logic       DE;
   coord_t     PIX_X;
   coord_t     PIX_Y;
   logic [6:0] CHAR_COL;
   logic [4:0] CHAR_ROW;
   logic [2:0] GLYPH_X;
   logic [3:0] GLYPH_Y;
   logic       FRAME_START;
   modport master (
      output HADDR, HTC,
      input  VADDR, HSYNC, VSYNC, DE, PIX_X, PIX_Y, CHAR_COL, CHAR_ROW, GLYPH_X, GLYPH_Y, FRAME_START
   );
   modport slave (
      input  HADDR, HTC,
      output VADDR, HSYNC, VSYNC, DE, PIX_X, PIX_Y, CHAR_COL, CHAR_ROW, GLYPH_X, GLYPH_Y, FRAME_START
   );
endinterface

// File: rtl/vga_sync_gen_vert_counter.sv
// vga_sync_gen_vert_counter: line counter advanced by HTC; v_eff_o is the line
// the current cycle belongs to, so decode at HADDR==0 already sees the new line.
module vga_sync_gen_vert_counter
   import vga_sync_gen_pkg::*;
#(
   parameter int V_TOTAL = V_TOTAL_D
) (
   input  logic   CLK,
   input  logic   RST,
   input  logic   htc_i,
   output coord_t v_o,
   output coord_t v_eff_o,
   output logic   wrap_o
);
   coord_t v_q, v_d;
   always_comb begin
      wrap_o = htc_i && (v_q == coord_t'(V_TOTAL - 1));
      v_d    = htc_i ? (wrap_o ? '0 : v_q + 10'd1) : v_q;
   end
   always_ff @(posedge CLK) v_q <= RST ? '0 : v_d;
   assign v_o     = v_q;
   assign v_eff_o = v_d;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: vertical counter plus registered sync, display-enable,
// pixel/text-cell coordinates and frame-start pulse, one cycle after HADDR/HTC.
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_D,
   parameter int H_FP      = H_FP_D,
   parameter int H_SYNC    = H_SYNC_D,
   parameter int H_BP      = H_BP_D,
   parameter int V_VISIBLE = V_VISIBLE_D,
   parameter int V_FP      = V_FP_D,
   parameter int V_SYNC    = V_SYNC_D,
   parameter int V_BP      = V_BP_D,
   parameter int HSYNC_POL = HSYNC_POL_D,
   parameter int VSYNC_POL = VSYNC_POL_D,
   parameter int CHAR_W    = CHAR_W_D,
   parameter int CHAR_H    = CHAR_H_D
) (
   input logic          CLK,
   input logic          RST,
   vga_sync_gen_if.slave bus
);
   localparam int     V_TOTAL = total(V_VISIBLE, V_FP, V_SYNC, V_BP);
   localparam coord_t H_TOT   = coord_t'(total(H_VISIBLE, H_FP, H_SYNC, H_BP));
   localparam coord_t H_VIS   = coord_t'(H_VISIBLE);
   localparam coord_t HS_BEG  = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_END  = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t V_VIS   = coord_t'(V_VISIBLE);
   localparam coord_t VS_BEG  = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_END  = coord_t'(V_VISIBLE + V_FP + V_SYNC);
   localparam int     CW_B    = $clog2(CHAR_W);
   localparam int     CH_B    = $clog2(CHAR_H);
   localparam logic   HP      = 1'(HSYNC_POL);
   localparam logic   VP      = 1'(VSYNC_POL);
   coord_t     v_eff;
   logic       wrap;
   logic       h_ok, de_d, hsync_d, vsync_d;
   coord_t     pix_x_d, pix_y_d;
   logic       de_q, hsync_q, vsync_q, frame_start_q;
   coord_t     pix_x_q, pix_y_q;
   logic [6:0] char_col_q;
   logic [4:0] char_row_q;
   logic [2:0] glyph_x_q;
   logic [3:0] glyph_y_q;
   vga_sync_gen_vert_counter #(.V_TOTAL(V_TOTAL)) u_vert (
      .CLK     (CLK),
      .RST     (RST),
      .htc_i   (bus.HTC),
      .v_o     (bus.VADDR),
      .v_eff_o (v_eff),
      .wrap_o  (wrap)
   );
   // Addresses past the end of the line are plain blanking.
   always_comb begin
      h_ok    = bus.HADDR < H_TOT;
      de_d    = h_ok && bus.HADDR < H_VIS && v_eff < V_VIS;
      hsync_d = (h_ok && bus.HADDR >= HS_BEG && bus.HADDR < HS_END) ? HP : ~HP;
      vsync_d = (v_eff >= VS_BEG && v_eff < VS_END) ? VP : ~VP;
      pix_x_d = de_d ? bus.HADDR : '0;
      pix_y_d = de_d ? v_eff : '0;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         de_q          <= 1'b0;
         hsync_q       <= ~HP;
         vsync_q       <= ~VP;
         frame_start_q <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         char_col_q    <= '0;
         char_row_q    <= '0;
         glyph_x_q     <= '0;
         glyph_y_q     <= '0;
      end else begin
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= wrap;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         char_col_q    <= 7'(pix_x_d >> CW_B);
         char_row_q    <= 5'(pix_y_d >> CH_B);
         glyph_x_q     <= 3'(pix_x_d & coord_t'(CHAR_W - 1));
         glyph_y_q     <= 4'(pix_y_d & coord_t'(CHAR_H - 1));
      end
   end
   assign bus.DE          = de_q;
   assign bus.HSYNC       = hsync_q;
   assign bus.VSYNC       = vsync_q;
   assign bus.FRAME_START = frame_start_q;
   assign bus.PIX_X       = pix_x_q;
   assign bus.PIX_Y       = pix_y_q;
   assign bus.CHAR_COL    = char_col_q;
   assign bus.CHAR_ROW    = char_row_q;
   assign bus.GLYPH_X     = glyph_x_q;
   assign bus.GLYPH_Y     = glyph_y_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed sweeps plus random HADDR/HTC/RST traffic checked
// against a line-number model that decodes the timing rules arithmetically.
module tb_vga_sync_gen;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   int   line_m = 0;
   int   fs_cnt = 0;
   vga_sync_gen_if bus();
   vga_sync_gen dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s line=%0d got=%0d expected=%0d", tag, line_m, got, exp);
      end
   endtask
   task automatic step(input int h, input bit t, input bit r);
      bit wrapped;
      bit de;
      int px, py;
      bus.HADDR = h[9:0];
      bus.HTC   = t;
      RST       = r;
      @(posedge CLK);
      #1;
      wrapped = !r && t && line_m == 524;
      line_m  = r ? 0 : (t ? (line_m + 1) % 525 : line_m);
      if (bus.FRAME_START) fs_cnt++;
      de = !r && h < 640 && line_m < 480;
      px = de ? h : 0;
      py = de ? line_m : 0;
      chk("VADDR", int'(bus.VADDR), line_m);
      chk("DE", int'(bus.DE), int'(de));
      chk("HSYNC", int'(bus.HSYNC), int'(r || !(h >= 656 && h <= 751)));
      chk("VSYNC", int'(bus.VSYNC), int'(r || !(line_m == 490 || line_m == 491)));
      chk("PIX_X", int'(bus.PIX_X), px);
      chk("PIX_Y", int'(bus.PIX_Y), py);
      chk("CHAR_COL", int'(bus.CHAR_COL), px / 8);
      chk("GLYPH_X", int'(bus.GLYPH_X), px % 8);
      chk("CHAR_ROW", int'(bus.CHAR_ROW), py / 16);
      chk("GLYPH_Y", int'(bus.GLYPH_Y), py % 16);
      chk("FRAME_START", int'(bus.FRAME_START), int'(wrapped));
   endtask
   task automatic new_line();
      step(0, 1'b1, 1'b0);
      step(639, 1'b0, 1'b0);
      step(640, 1'b0, 1'b0);
      step(656, 1'b0, 1'b0);
      step(751, 1'b0, 1'b0);
      step(752, 1'b0, 1'b0);
      step($urandom_range(0, 1023), 1'b0, 1'b0);
   endtask
   initial begin
      int fs0;
      bus.HADDR = '0;
      bus.HTC   = 1'b0;
      for (int i = 0; i < 3; i++) step($urandom_range(0, 1023), 1'($urandom_range(0, 1)), 1'b1);
      for (int h = 0; h < 800; h++) step(h, 1'b0, 1'b0);
      while (line_m != 10) new_line();
      chk("line10_PIX_Y", int'(bus.VADDR), 10);
      while (line_m != 137) new_line();
      for (int h = 0; h < 800; h++) begin
         step(h, 1'b0, 1'b0);
         if (h == 137) begin
            chk("cell137_COL", int'(bus.CHAR_COL), 17);
            chk("cell137_GX", int'(bus.GLYPH_X), 1);
            chk("cell137_ROW", int'(bus.CHAR_ROW), 8);
            chk("cell137_GY", int'(bus.GLYPH_Y), 9);
         end
      end
      while (line_m != 0) new_line();
      fs0 = fs_cnt;
      for (int l = 0; l < 525; l++) new_line();
      chk("frame_pulses", fs_cnt - fs0, 1);
      while (line_m != 300) new_line();
      step(0, 1'b1, 1'b1);
      chk("rst_htc_VADDR", int'(bus.VADDR), 0);
      step(5, 1'b1, 1'b0);
      step(5, 1'b1, 1'b0);
      step(900, 1'b0, 1'b0);
      chk("h900_VADDR", int'(bus.VADDR), 2);
      for (int i = 0; i < 30000; i++) begin
         int h;
         h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 799);
         step(h, $urandom_range(0, 3) == 0, $urandom_range(0, 999) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Direct downstream consumer of the horizontal pixel counter in the VGA text-mode pipeline.
- Takes the horizontal address and the line-advance pulse. Maintains the vertical line counter.
- Produces registered HSYNC/VSYNC, display-enable, pixel coordinates, text-cell/glyph coordinates and a frame-start pulse for the character/font fetch stages.
- Default timing is 640x480@60, 800x525 total.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, active level of HSYNC (0 = active-low)
- VSYNC_POL, 0, active level of VSYNC
- CHAR_W, 8, glyph width in pixels (power of 2)
- CHAR_H, 16, glyph height in pixels (power of 2)

Ports:
- CLK  in  1  pixel clock
- RST  in  1  reset, synchronous, active-high
- HADDR  in  10  horizontal address, 0..H_TOTAL-1
- HTC  in  1  line-advance pulse, one cycle, coincident with HADDR==0
- VADDR  out  10  current vertical line, 0..V_TOTAL-1
- HSYNC  out  1  horizontal sync, registered
- VSYNC  out  1  vertical sync, registered
- DE  out  1  display enable (visible region), registered
- PIX_X  out  10  visible x, 0..H_VISIBLE-1; 0 when DE=0
- PIX_Y  out  10  visible y, 0..V_VISIBLE-1; 0 when DE=0
- CHAR_COL  out  7  PIX_X / CHAR_W (0..79)
- CHAR_ROW  out  5  PIX_Y / CHAR_H (0..29)
- GLYPH_X  out  3  PIX_X mod CHAR_W
- GLYPH_Y  out  4  PIX_Y mod CHAR_H
- FRAME_START  out  1  one-cycle pulse at start of line 0

Behaviour:
- H_TOTAL = sum of H params (800). V_TOTAL = sum of V params (525).
- Vertical counter v_q (10-bit) is updated on posedge CLK:
  - RST: v_q <= 0.
  - Else if HTC: v_q <= (v_q == V_TOTAL-1) ? 0 : v_q+1.
  - Else hold.
  - VADDR = v_q.
- Effective line v_eff = HTC ? next value of v_q : v_q. All decode uses v_eff, so outputs for HADDR==0 already reflect the new line.
- Output latency: exactly 1 cycle from HADDR/HTC to all registered outputs.
- HSYNC active iff H_VISIBLE+H_FP <= HADDR < H_VISIBLE+H_FP+H_SYNC (656..751).
- VSYNC active iff V_VISIBLE+V_FP <= v_eff < V_VISIBLE+V_FP+V_SYNC (490..491).
- Active level of each sync = its _POL parameter; inactive level = the inverse.
- DE = (HADDR < H_VISIBLE) && (v_eff < V_VISIBLE).
- When DE=1: PIX_X=HADDR, PIX_Y=v_eff. Cell/glyph fields are bit slices (CHAR_W, CHAR_H are powers of 2). No dividers.
- When DE=0: PIX_X, PIX_Y, CHAR_*, GLYPH_* all 0.
- FRAME_START = 1 for the one output cycle when HTC wraps v_q from V_TOTAL-1 to 0. Not asserted after reset.
- Reset values:
  - VADDR=0, DE=0, FRAME_START=0.
  - HSYNC=~HSYNC_POL, VSYNC=~VSYNC_POL (inactive).
  - All coordinate outputs 0.
- Boundary conditions:
  - HADDR >= H_TOTAL: treated as blanking (DE=0, HSYNC inactive). Vertical counter unaffected.
  - HTC with HADDR!=0: v_q still advances; decode uses the supplied HADDR.
  - RST together with HTC: RST wins; v_q=0, no FRAME_START.
  - RST mid-frame: next cycle all outputs at reset values. The first line after reset is line 0.
  - v_q is always bounded; no state other than v_q and output registers.

Decomposition:
- Shared include vga_timing_defs: default 640x480 timing constants, H_TOTAL/V_TOTAL derivation, sync polarity constants. Reused by the horizontal counter and the text/font stages.
- One natural sub-module: vert_counter (v_q register, wrap logic, v_eff and wrap-flag outputs).
- Sync/DE/coordinate decode and output registers stay in vga_sync_gen.

Test Plan:
- RST held 3 cycles, then HADDR sweep 0..799 with HTC=0:
  - DE=1 for inputs 0..639 (output one cycle later), PIX_Y=0, VADDR=0.
  - HSYNC low for inputs 656..751, high elsewhere; VSYNC high throughout.
- HADDR=0 with HTC=1 while v_q=9:
  - Next cycle VADDR=10, PIX_Y=10, PIX_X=0, DE=1.
- Drive input HADDR=0..799 while VADDR=137 (input HADDR=137 at line 137):
  - CHAR_COL=17, GLYPH_X=1, CHAR_ROW=8, GLYPH_Y=9.
- Full frame of 525 HTC pulses:
  - VSYNC low exactly on lines 490 and 491.
  - DE=0 on lines 480..524.
  - FRAME_START pulses once, when line 524 wraps to 0.
- RST asserted together with HTC on line 300:
  - Next cycle VADDR=0, FRAME_START=0, DE=0, HSYNC=1, VSYNC=1.
- HADDR=900, HTC=0:
  - DE=0, HSYNC inactive, PIX_X=0, VADDR unchanged.
